mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning the number of wait cycles after each sel change before mux_out is sampled; legal range 0..15.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  scan request; acted on only in IDLE.
REQ-005 mask  input  16  channel enable; bit i=1 SHALL mean channel i is scanned; captured on an accepted start.
REQ-006 sel  output  4  select code driven to the downstream 16:1 mux (in[15:0], sel[3:0], out).
REQ-007 mux_out  input  1  the 16:1 mux output, fed back for sampling.
REQ-008 data  output  16  assembled scan word; bit i holds the sample of channel i.
REQ-009 valid  output  1  data is complete and stable.
REQ-010 ready  input  1  consumer accepts data.
REQ-011 busy  output  1  high in every state other than IDLE.

Function
REQ-012 The block SHALL implement three states: IDLE, WAIT and DONE.
REQ-013 In IDLE, start=1 with mask!=0 SHALL capture mask into mask_q, clear data to 0, and set sel to the index of the lowest set bit of mask.
REQ-014 On that same edge, the block SHALL load the settle counter with SETTLE and enter WAIT.
REQ-015 In IDLE, start=1 with mask==0 SHALL clear data to 0 and enter DONE directly.
REQ-016 In WAIT, a counter value other than 0 SHALL decrement the counter by 1, with no other state change.
REQ-017 In WAIT, a counter value of 0 SHALL write mux_out into data[sel].
REQ-018 On that same edge, if mask_q has a set bit above sel, the block SHALL move sel to the lowest such bit, reload the counter with SETTLE and stay in WAIT; otherwise it SHALL enter DONE with sel unchanged.
REQ-019 Each enabled channel SHALL occupy exactly SETTLE+1 cycles in WAIT.
REQ-020 For N enabled channels with start accepted at edge k, valid SHALL rise after edge k+N*(SETTLE+1); for mask==0 it SHALL rise after edge k+1.
REQ-021 Disabled channels SHALL read 0 in data, and their sel codes SHALL never be driven during a scan.
REQ-022 In DONE, valid SHALL be 1 and data SHALL hold.
REQ-023 In DONE, ready=1 SHALL cause a return to IDLE, with valid low after that edge; valid SHALL stay high for as long as ready=0.
REQ-024 The start input SHALL be ignored in WAIT and DONE; a start asserted on the same edge as the DONE->IDLE transition SHALL NOT be accepted.
REQ-025 data SHALL change only on an accepted start or on a sample edge, and SHALL never change while valid=1.
REQ-026 Scanning channel 15 SHALL end the scan; sel SHALL NOT wrap to 0.
REQ-027 Changes to mask after an accepted start SHALL have no effect on the current scan.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE, sel=0, data=0, valid=0, busy=0, counter=0 and mask_q=0.
REQ-029 Reset SHALL override every other input, including start and ready on the same edge.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no partial valid pulse.
REQ-031 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-032 SETTLE=1, mask=16'hFFFF, mux model out=in[sel] with in=16'hA5C3, ready=1 -> sel steps 0..15, valid after 32 cycles, data=16'hA5C3.
REQ-033 SETTLE=0, mask=16'h8001, in=16'hFFFF -> sel visits only 0 and 15, valid after 2 cycles, data=16'h8001.
REQ-034 mask=16'h0000, start -> valid after 1 cycle with data=0, and sel stays 0.
REQ-035 ready held 0 for 10 cycles in DONE while start pulses and in changes -> valid stays 1, data is unchanged and no new scan starts; ready=1 -> IDLE.
REQ-036 rst_n=0 during WAIT at channel 5 of a full-mask scan -> next cycle state IDLE, all outputs 0; a following start rescans from channel 0.
REQ-037 SETTLE=15, mask=16'h0010 -> sel=4 held for 16 cycles, exactly one sample taken, valid after 16 cycles.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Scan-controller bus: request/capture on one side, result handshake and mux select on the other.
interface mux_scan_ctrl_if;
  logic        start;
  logic [15:0] mask;
  logic [3:0]  sel;
  logic        mux_out;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        busy;

  modport master (
    output start, mask, mux_out, ready,
    input  sel, data, valid, busy
  );

  modport slave (
    input  start, mask, mux_out, ready,
    output sel, data, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks the enabled channels of an external 16:1 mux, waits SETTLE cycles per channel,
// samples the mux output into a 16-bit word and hands it over with a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  scan_if
);

  localparam int unsigned NCH  = 16;
  localparam int unsigned SELW = 4;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [NCH-1:0]  mask_q;
  logic [NCH-1:0]  data_q;
  logic [SELW-1:0] sel_q;
  logic [CNTW-1:0] cnt_q;
  logic            valid_q;
  logic            busy_q;

  logic [NCH-1:0]  above_mask;
  logic [SELW-1:0] first_sel;
  logic [SELW-1:0] next_sel;

  function automatic logic [SELW-1:0] lowest_idx(input logic [NCH-1:0] v);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = SELW'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current one; empty once channel 15 is reached.
  assign above_mask = mask_q & ~((NCH'(2) << sel_q) - NCH'(1));
  assign first_sel  = lowest_idx(scan_if.mask);
  assign next_sel   = lowest_idx(above_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_if.start) begin
            data_q <= '0;
            busy_q <= 1'b1;
            if (scan_if.mask != '0) begin
              mask_q  <= scan_if.mask;
              sel_q   <= first_sel;
              cnt_q   <= CNTW'(SETTLE);
              state_q <= WAIT;
            end else begin
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNTW'(1);
          end else begin
            data_q[sel_q] <= scan_if.mux_out;
            if (above_mask != '0) begin
              sel_q <= next_sel;
              cnt_q <= CNTW'(SETTLE);
            end else begin
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (scan_if.ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign scan_if.sel   = sel_q;
  assign scan_if.data  = data_q;
  assign scan_if.valid = valid_q;
  assign scan_if.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: three controllers (SETTLE = 1, 0, 15) each driving a behavioural 16:1 mux.
module tb_mux_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_r [3];
  logic [15:0] mask_r  [3];
  logic [15:0] in_r    [3];
  logic        ready_r [3];
  logic [3:0]  sel_w   [3];
  logic [15:0] data_w  [3];
  logic        valid_w [3];
  logic        busy_w  [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    mux_scan_ctrl_if bus ();
    assign bus.start   = start_r[g];
    assign bus.mask    = mask_r[g];
    assign bus.ready   = ready_r[g];
    assign bus.mux_out = in_r[g][bus.sel];
    assign sel_w[g]    = bus.sel;
    assign data_w[g]   = bus.data;
    assign valid_w[g]  = bus.valid;
    assign busy_w[g]   = bus.busy;
    mux_scan_ctrl #(.SETTLE(S)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (bus)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq({tag, "_sel"},   32'(sel_w[k]),   32'd0);
      check_eq({tag, "_data"},  32'(data_w[k]),  32'd0);
      check_eq({tag, "_valid"}, 32'(valid_w[k]), 32'd0);
      check_eq({tag, "_busy"},  32'(busy_w[k]),  32'd0);
    end
  endtask

  // Called at a negedge: start is sampled on the next rising edge. lat counts edges from the
  // start edge (inclusive) until valid is seen; waitc counts cycles spent scanning.
  task automatic run_scan(input int unit, input logic [15:0] m, input logic [15:0] inv,
                          input logic [3:0] exp_first, input int exp_wait, input int exp_lat,
                          input logic [15:0] exp_data, input string tag);
    int          lat;
    int          waitc;
    logic [15:0] visited;
    mask_r[unit]  = m;
    in_r[unit]    = inv;
    start_r[unit] = 1'b1;
    @(negedge clk);
    start_r[unit] = 1'b0;
    mask_r[unit]  = ~m;
    check_eq({tag, "_first_sel"}, 32'(sel_w[unit]), 32'(exp_first));
    check_eq({tag, "_busy"}, 32'(busy_w[unit]), 32'd1);
    lat     = 1;
    waitc   = 0;
    visited = '0;
    while (!valid_w[unit] && lat < 400) begin
      visited = visited | (16'(1) << sel_w[unit]);
      waitc++;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_wait_cycles"}, 32'(waitc), 32'(exp_wait));
    check_eq({tag, "_sel_visited"}, 32'(visited), 32'(m));
    check_eq({tag, "_data"}, 32'(data_w[unit]), 32'(exp_data));
    check_eq({tag, "_busy_done"}, 32'(busy_w[unit]), 32'd1);
    if (ready_r[unit]) begin
      @(negedge clk);
      check_eq({tag, "_valid_drop"}, 32'(valid_w[unit]), 32'd0);
      check_eq({tag, "_busy_drop"}, 32'(busy_w[unit]), 32'd0);
      check_eq({tag, "_data_keep"}, 32'(data_w[unit]), 32'(exp_data));
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b1;
      mask_r[k]  = 16'hFFFF;
      in_r[k]    = 16'hFFFF;
      ready_r[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b0;
      ready_r[k] = 1'b0;
    end

    // First edge out of reset accepts the start; full mask at SETTLE=1.
    rst_n      = 1'b1;
    ready_r[0] = 1'b1;
    run_scan(0, 16'hFFFF, 16'hA5C3, 4'd0, 32, 33, 16'hA5C3, "full_s1");

    // Sparse mask at SETTLE=0: only channels 0 and 15.
    ready_r[1] = 1'b1;
    run_scan(1, 16'h8001, 16'hFFFF, 4'd0, 2, 3, 16'h8001, "ends_s0");
    check_eq("ends_s0_sel_no_wrap", 32'(sel_w[1]), 32'd15);

    // Empty mask goes straight to DONE with zero data and sel untouched.
    ready_r[2] = 1'b1;
    @(negedge clk);
    run_scan(2, 16'h0000, 16'hFFFF, 4'd0, 0, 1, 16'h0000, "empty");

    // Single channel at SETTLE=15.
    run_scan(2, 16'h0010, 16'h0010, 4'd4, 16, 17, 16'h0010, "one_s15");
    check_eq("one_s15_sel", 32'(sel_w[2]), 32'd4);

    // DONE holds while ready is low, ignoring start pulses and mux changes.
    ready_r[0] = 1'b0;
    @(negedge clk);
    run_scan(0, 16'h0F0F, 16'h3C3C, 4'd0, 16, 17, 16'h0C0C, "hold");
    for (int i = 0; i < 10; i++) begin
      start_r[0] = i[0];
      mask_r[0]  = 16'h0001;
      in_r[0]    = 16'($urandom);
      @(negedge clk);
      check_eq("hold_valid", 32'(valid_w[0]), 32'd1);
      check_eq("hold_data", 32'(data_w[0]), 32'h0C0C);
      check_eq("hold_busy", 32'(busy_w[0]), 32'd1);
    end
    start_r[0] = 1'b1;
    ready_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    check_eq("release_valid", 32'(valid_w[0]), 32'd0);
    check_eq("release_busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    check_eq("release_no_restart", 32'(busy_w[0]), 32'd0);

    // Reset in the middle of channel 5 aborts without a valid pulse.
    mask_r[0]  = 16'hFFFF;
    in_r[0]    = 16'h1234;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    guard = 0;
    while (sel_w[0] != 4'd5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("abort_reached_ch5", 32'(sel_w[0]), 32'd5);
    check_eq("abort_partial_data", 32'(data_w[0]), 32'h0014);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    rst_n = 1'b1;
    run_scan(0, 16'hFFFF, 16'h1234, 4'd0, 32, 33, 16'h1234, "rescan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
